// File: rtl/param_updown_counter_if.sv
// Control/status bundle for param_updown_counter.
// The master drives the controls and the slave (the counter) returns count and flags.
interface param_updown_counter_if #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
);
    logic                  en;
    logic                  up;
    logic                  sat;
    logic                  clr;
    logic                  load;
    logic [WIDTH-1:0]      load_val;
    logic [PRESCALE_W-1:0] prescale;
    logic [WIDTH-1:0]      cmp_val;
    logic                  ovf_clr;
    logic [WIDTH-1:0]      count;
    logic                  tc;
    logic                  ovf;
    logic                  cmp_match;

    modport master (
        output en, up, sat, clr, load, load_val, prescale, cmp_val, ovf_clr,
        input  count, tc, ovf, cmp_match
    );

    modport slave (
        input  en, up, sat, clr, load, load_val, prescale, cmp_val, ovf_clr,
        output count, tc, ovf, cmp_match
    );
endinterface

// File: rtl/param_updown_counter.sv
// Prescaled up/down counter over modulus MAX_VAL+1 with wrap/saturate modes,
// clear/load, compare match, a one-cycle terminal-count pulse and a sticky overflow flag.
module param_updown_counter #(
    parameter int WIDTH      = 8,
    parameter int MAX_VAL    = (2 ** WIDTH) - 1,
    parameter int PRESCALE_W = 4
) (
    input logic                   clk,
    input logic                   rst_n,
    param_updown_counter_if.slave bus
);
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0]      r_count;
    logic [PRESCALE_W-1:0] r_pre;
    logic                  r_tc;
    logic                  r_ovf;

    logic                  w_pre_hit;
    logic                  w_step;
    logic                  w_at_bound;
    logic [WIDTH-1:0]      w_step_val;
    logic [WIDTH-1:0]      w_load_val;

    assign w_pre_hit  = (r_pre == bus.prescale);
    assign w_step     = bus.en && !bus.clr && !bus.load && w_pre_hit;
    assign w_at_bound = bus.up ? (r_count == MAX) : (r_count == '0);
    // Loads above the modulus clamp so the count can never leave [0, MAX].
    assign w_load_val = (bus.load_val > MAX) ? MAX : bus.load_val;

    always_comb begin
        w_step_val = r_count;
        if (w_at_bound) begin
            if (bus.sat)
                w_step_val = r_count;
            else
                w_step_val = bus.up ? '0 : MAX;
        end else begin
            w_step_val = bus.up ? (r_count + 1'b1) : (r_count - 1'b1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_pre   <= '0;
            r_tc    <= 1'b0;
        end else if (bus.clr) begin
            r_count <= '0;
            r_pre   <= '0;
            r_tc    <= 1'b0;
        end else if (bus.load) begin
            r_count <= w_load_val;
            r_pre   <= '0;
            r_tc    <= 1'b0;
        end else if (bus.en) begin
            // A prescale lowered below r_pre just lets r_pre wrap through zero.
            if (w_pre_hit) begin
                r_pre   <= '0;
                r_count <= w_step_val;
                r_tc    <= w_at_bound;
            end else begin
                r_pre <= r_pre + 1'b1;
                r_tc  <= 1'b0;
            end
        end else begin
            r_tc <= 1'b0;
        end
    end

    // Setting wins over ovf_clr on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_ovf <= 1'b0;
        else if (w_step && w_at_bound)
            r_ovf <= 1'b1;
        else if (bus.ovf_clr)
            r_ovf <= 1'b0;
    end

    assign bus.count     = r_count;
    assign bus.tc        = r_tc;
    assign bus.ovf       = r_ovf;
    assign bus.cmp_match = (r_count == bus.cmp_val);
endmodule

// File: tb/tb_param_updown_counter.sv
// Directed table-driven bench for param_updown_counter at WIDTH=4, MAX_VAL=9.
// A hand-written sequence covers asynchronous reset asserted mid-count.
module tb_param_updown_counter;
    localparam int WIDTH = 4;
    localparam int PW    = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    param_updown_counter_if #(.WIDTH(WIDTH), .PRESCALE_W(PW)) bus ();

    param_updown_counter #(.WIDTH(WIDTH), .MAX_VAL(9), .PRESCALE_W(PW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en, up, sat, clr, load;
        logic [3:0] lv, ps, cmp;
        logic       oc;
        logic [3:0] cnt;
        logic       tc, ovf, m;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic en, up, sat, clr, load,
                                input logic [3:0] lv, ps, cmp, input logic oc,
                                input logic [3:0] cnt, input logic tc, ovf, m);
        vec_t v;
        v.en = en; v.up = up; v.sat = sat; v.clr = clr; v.load = load;
        v.lv = lv; v.ps = ps; v.cmp = cmp; v.oc = oc;
        v.cnt = cnt; v.tc = tc; v.ovf = ovf; v.m = m;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.en = v.en; bus.up = v.up; bus.sat = v.sat; bus.clr = v.clr;
        bus.load = v.load; bus.load_val = v.lv; bus.prescale = v.ps;
        bus.cmp_val = v.cmp; bus.ovf_clr = v.oc;
    endtask

    task automatic check_outs(input int idx, input vec_t v);
        chk($sformatf("v%0d count", idx), int'(bus.count), int'(v.cnt));
        chk($sformatf("v%0d tc", idx), int'(bus.tc), int'(v.tc));
        chk($sformatf("v%0d ovf", idx), int'(bus.ovf), int'(v.ovf));
        chk($sformatf("v%0d cmp_match", idx), int'(bus.cmp_match), int'(v.m));
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Up-count wrap, modulus 10, compare at 5
        for (int i = 1; i <= 9; i++)
            vecs.push_back(mk(1,1,0,0,0, 0,0,5,0, 4'(i), 0, 0, (i == 5)));
        vecs.push_back(mk(1,1,0,0,0, 0,0,5,0, 0, 1, 1, 0));
        vecs.push_back(mk(1,1,0,0,0, 0,0,5,0, 1, 0, 1, 0));
        vecs.push_back(mk(1,1,0,0,0, 0,0,5,0, 2, 0, 1, 0));
        // clr keeps ovf; ovf_clr alone clears it
        vecs.push_back(mk(1,1,0,1,0, 0,0,5,0, 0, 0, 1, 0));
        vecs.push_back(mk(0,1,0,0,0, 0,0,5,1, 0, 0, 0, 0));
        // Down from 0 wraps to 9
        vecs.push_back(mk(1,0,0,0,0, 0,0,5,0, 9, 1, 1, 0));
        vecs.push_back(mk(1,0,0,0,0, 0,0,5,0, 8, 0, 1, 0));
        vecs.push_back(mk(1,0,0,0,0, 0,0,5,0, 7, 0, 1, 0));
        // load beats step
        vecs.push_back(mk(1,0,0,0,1, 1,0,5,0, 1, 0, 1, 0));
        vecs.push_back(mk(1,0,0,0,0, 0,0,5,0, 0, 0, 1, 0));
        // Saturate at 0: tc every cycle; set beats ovf_clr
        vecs.push_back(mk(1,0,1,0,0, 0,0,5,0, 0, 1, 1, 0));
        vecs.push_back(mk(1,0,1,0,0, 0,0,5,0, 0, 1, 1, 0));
        vecs.push_back(mk(1,0,1,0,0, 0,0,5,1, 0, 1, 1, 0));
        vecs.push_back(mk(0,0,1,0,0, 0,0,5,1, 0, 0, 0, 0));
        // Load clamps to MAX_VAL; clr beats load
        vecs.push_back(mk(0,1,0,0,1, 15,0,9,0, 9, 0, 0, 1));
        vecs.push_back(mk(0,1,0,1,1, 3,0,9,0, 0, 0, 0, 0));
        vecs.push_back(mk(0,1,0,0,1, 8,0,5,0, 8, 0, 0, 0));
        // Saturate at MAX then wrap
        vecs.push_back(mk(1,1,1,0,0, 0,0,5,0, 9, 0, 0, 0));
        vecs.push_back(mk(1,1,1,0,0, 0,0,5,0, 9, 1, 1, 0));
        vecs.push_back(mk(1,1,0,0,0, 0,0,5,0, 0, 1, 1, 0));
        // prescale=3 with en dropped mid-period
        vecs.push_back(mk(1,1,0,1,0, 0,3,5,0, 0, 0, 1, 0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(1,1,0,0,0, 0,3,5,0, 0, 0, 1, 0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(1,1,0,0,0, 0,3,5,0, 1, 0, 1, 0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0,1,0,0,0, 0,3,5,0, 1, 0, 1, 0));
        vecs.push_back(mk(1,1,0,0,0, 0,3,5,0, 1, 0, 1, 0));
        vecs.push_back(mk(1,1,0,0,0, 0,3,5,0, 2, 0, 1, 0));

        rst_n = 1'b0;
        drive(mk(0,0,0,0,0, 0,0,0,0, 0,0,0,0));
        #1;
        chk("reset count", int'(bus.count), 0);
        chk("reset tc", int'(bus.tc), 0);
        chk("reset ovf", int'(bus.ovf), 0);
        chk("reset cmp_match", int'(bus.cmp_match), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i]);
            @(posedge clk);
            #1;
            check_outs(i, vecs[i]);
            @(negedge clk);
        end

        // Async reset mid-count at 7 with ovf set, then restart with full prescale period
        drive(mk(0,1,0,0,1, 7,1,5,0, 0,0,0,0));
        @(posedge clk); #1;
        chk("pre-reset load", int'(bus.count), 7);
        @(negedge clk);
        drive(mk(1,1,0,0,0, 0,1,5,0, 0,0,0,0));
        @(posedge clk); #1;
        chk("pre-reset hold", int'(bus.count), 7);
        chk("pre-reset ovf", int'(bus.ovf), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst count", int'(bus.count), 0);
        chk("async rst tc", int'(bus.tc), 0);
        chk("async rst ovf", int'(bus.ovf), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("restart edge1", int'(bus.count), 0);
        @(posedge clk); #1;
        chk("restart edge2", int'(bus.count), 1);
        chk("restart tc", int'(bus.tc), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/param_updown_counter.md
Name: param_updown_counter

Overview:
Parametrised successor to the team's fixed 4-bit enable counter. Counts up or down at a programmable prescaled rate over a configurable modulus, with wrap or saturate mode, synchronous clear and load, compare match, and terminal-count/overflow flags. Intended as the reusable counter/timer core behind the tile's dedicated I/O wrappers.

Parameters:
WIDTH, 8, counter width in bits (2..16)
MAX_VAL, 2**WIDTH-1, top count value; modulus = MAX_VAL+1; must be <= 2**WIDTH-1
PRESCALE_W, 4, prescaler field width (1..8)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  reset, asynchronous, active-low
en  input  1  count enable; gates prescaler advance
up  input  1  direction: 1 = up, 0 = down; sampled on each step
sat  input  1  mode: 1 = saturate at bound, 0 = wrap
clr  input  1  synchronous clear
load  input  1  synchronous load of load_val
load_val  input  WIDTH  load value
prescale  input  PRESCALE_W  step every prescale+1 enabled cycles
cmp_val  input  WIDTH  compare value
ovf_clr  input  1  clears sticky ovf
count  output  WIDTH  current count (registered)
tc  output  1  one-cycle terminal-count pulse (registered)
ovf  output  1  sticky boundary-hit flag (registered)
cmp_match  output  1  count == cmp_val (combinational from count register)

Behaviour:
- Reset (rst_n low, async): count=0, prescaler=0, tc=0, ovf=0; cmp_match follows (1 if cmp_val==0).
- Priority per edge: clr > load > step > hold.
- clr: count<=0, prescaler<=0, tc<=0. ovf unaffected.
- load: count<=min(load_val, MAX_VAL), prescaler<=0, tc<=0.
- Prescaler: if en and no clr/load: when pre==prescale then pre<=0 and step fires this edge, else pre<=pre+1. en low holds pre and count. prescale=0 -> step every enabled cycle. prescale lowered below current pre: next enabled edge, pre==prescale never equal while pre>prescale, so pre wraps at 2**PRESCALE_W-1 to 0 naturally; no extra handling.
- Step, up=1: count<MAX_VAL -> count+1. count==MAX_VAL -> wrap: 0; sat: hold MAX_VAL.
- Step, up=0: count>0 -> count-1. count==0 -> wrap: MAX_VAL; sat: hold 0.
- Boundary step (either direction, either mode): tc<=1 on that edge (visible cycle after), ovf<=1.
- tc=0 on every edge without a boundary step; never high two consecutive cycles unless consecutive boundary steps (prescale=0, sat=1 at bound).
- ovf: set by boundary step; cleared by ovf_clr; set wins if both same edge.
- Direction/mode changes take effect on the next step; no pipeline.
- Non-power-of-two MAX_VAL: count never exceeds MAX_VAL under any stimulus.
- Reset asserted mid-count: all state to reset values immediately, independent of clk.

Test Plan:
- WIDTH=4, MAX_VAL=9, prescale=0, up=1, sat=0, en=1 from reset, 12 cycles -> count 1..9,0,1,2; tc high exactly the cycle count shows 0; ovf=1 thereafter.
- Same, up=0 from 0 -> count 9,8,...; tc on first step; sat=1 at 0 with up=0 -> count holds 0, tc high every cycle, ovf=1.
- prescale=3, en=1 -> count increments every 4th cycle; drop en for 5 cycles mid-period -> count and phase frozen, resumes with remaining cycles.
- load=1, load_val=15, MAX_VAL=9 -> count=9; load and clr same edge -> count=0; load=1 with en=1 -> loaded value, no step that edge.
- cmp_val=5 -> cmp_match high only while count==5; ovf_clr and boundary step same edge -> ovf stays 1; ovf_clr alone -> 0.
- Assert rst_n low between clock edges at count=7 -> count, tc, ovf 0 before next edge; release -> counting restarts from 0 with full prescale period.
